// File: rtl/spi_controller.sv
`default_nettype none
// ============================================================================
//  Module      : spi_controller
//  Description : SPI mode-0 initiator that emits write-only 16-bit frames
//                {rw, addr[6:0], data[7:0]}, MSB first, on nCS/SCLK/COPI.
//                A frame is SETUP (CLK_DIV cycles, SCLK low, first bit on
//                COPI), SHIFT (16 SCLK periods of CLK_DIV high + CLK_DIV
//                low; the low half after the 16th fall doubles as CS hold),
//                then GAP (nCS high for 2*CLK_DIV cycles) and a done pulse.
//  Parameters  : CLK_DIV  clk cycles per SCLK half-period, legal 2..255
//  Ports       : clk, rst_n (async, active low)
//                start, rw, addr[6:0], data[7:0]   frame request/contents
//                abort                             only with SPI_CTRL_ABORT_EN
//                busy, done                        status
//                nCS_out, SCLK_out, COPI_out       SPI pins (all registered)
//  Options     : `define SPI_CTRL_ABORT_EN adds the abort input, which cuts a
//                frame in SETUP/SHIFT short and jumps straight to GAP.
//  Revision    : 1.0  initial release
// ============================================================================
module spi_controller #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       rw,
    input  logic [6:0] addr,
    input  logic [7:0] data,
`ifdef SPI_CTRL_ABORT_EN
    input  logic       abort,
`endif
    output logic       busy,
    output logic       done,
    output logic       nCS_out,
    output logic       SCLK_out,
    output logic       COPI_out
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_SHIFT = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    // Every phase (setup, each SCLK half, each gap half) is CLK_DIV cycles.
    localparam logic [7:0] c_reload = 8'(CLK_DIV - 1);

    state_t      r_state, w_state;
    logic [7:0]  r_cnt, w_cnt;
    logic [4:0]  r_bit_cnt, w_bit_cnt;
    logic [15:0] r_sr, w_sr;
    logic        r_busy, w_busy;
    logic        r_done, w_done;
    logic        r_ncs, w_ncs;
    logic        r_sclk, w_sclk;
    logic        r_copi, w_copi;
    logic        w_abort;

`ifdef SPI_CTRL_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= 8'd0;
            r_bit_cnt <= 5'd0;
            r_sr      <= 16'd0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_ncs     <= 1'b1;
            r_sclk    <= 1'b0;
            r_copi    <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_cnt     <= w_cnt;
            r_bit_cnt <= w_bit_cnt;
            r_sr      <= w_sr;
            r_busy    <= w_busy;
            r_done    <= w_done;
            r_ncs     <= w_ncs;
            r_sclk    <= w_sclk;
            r_copi    <= w_copi;
        end
    end

    always_comb begin
        w_state   = r_state;
        w_cnt     = r_cnt;
        w_bit_cnt = r_bit_cnt;
        w_sr      = r_sr;
        w_busy    = r_busy;
        w_done    = 1'b0;
        w_ncs     = r_ncs;
        w_sclk    = r_sclk;
        w_copi    = r_copi;

        case (r_state)
            ST_IDLE: begin
                // Start wins over abort here: abort is only looked at later.
                if (start) begin
                    w_sr      = {rw, addr, data};
                    w_state   = ST_SETUP;
                    w_cnt     = c_reload;
                    w_bit_cnt = 5'd0;
                    w_busy    = 1'b1;
                    w_ncs     = 1'b0;
                    w_sclk    = 1'b0;
                    w_copi    = rw;
                end
            end

            ST_SETUP: begin
                if (w_abort) begin
                    w_state   = ST_GAP;
                    w_cnt     = c_reload;
                    w_bit_cnt = 5'd0;
                    w_ncs     = 1'b1;
                    w_sclk    = 1'b0;
                    w_copi    = 1'b0;
                end else if (r_cnt != 8'd0) begin
                    w_cnt = r_cnt - 8'd1;
                end else begin
                    w_state = ST_SHIFT;
                    w_sclk  = 1'b1;
                    w_cnt   = c_reload;
                end
            end

            ST_SHIFT: begin
                if (w_abort) begin
                    w_state   = ST_GAP;
                    w_cnt     = c_reload;
                    w_bit_cnt = 5'd0;
                    w_ncs     = 1'b1;
                    w_sclk    = 1'b0;
                    w_copi    = 1'b0;
                end else if (r_cnt != 8'd0) begin
                    w_cnt = r_cnt - 8'd1;
                end else if (r_sclk) begin
                    // Falling edge: present the next bit. The register shifts
                    // in zeros, so after the 16th fall COPI drops to 0.
                    w_sclk    = 1'b0;
                    w_cnt     = c_reload;
                    w_bit_cnt = r_bit_cnt + 5'd1;
                    w_sr      = {r_sr[14:0], 1'b0};
                    w_copi    = r_sr[14];
                end else if (r_bit_cnt == 5'd16) begin
                    // Low half after the last fall was the CS hold time.
                    w_state   = ST_GAP;
                    w_cnt     = c_reload;
                    w_bit_cnt = 5'd0;
                    w_ncs     = 1'b1;
                end else begin
                    w_sclk = 1'b1;
                    w_cnt  = c_reload;
                end
            end

            ST_GAP: begin
                // Two CLK_DIV halves; bit_cnt[0] tracks which half we are in
                // so the 8-bit counter never needs to hold 2*CLK_DIV-1.
                if (r_cnt != 8'd0) begin
                    w_cnt = r_cnt - 8'd1;
                end else if (!r_bit_cnt[0]) begin
                    w_bit_cnt = 5'd1;
                    w_cnt     = c_reload;
                end else begin
                    w_state   = ST_IDLE;
                    w_bit_cnt = 5'd0;
                    w_busy    = 1'b0;
                    w_done    = 1'b1;
                end
            end

            default: begin
                w_state = ST_IDLE;
            end
        endcase
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign nCS_out  = r_ncs;
    assign SCLK_out = r_sclk;
    assign COPI_out = r_copi;

endmodule
`default_nettype wire

// File: tb/tb_spi_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_controller
//  Description : Directed bench for spi_controller. Instance 0 uses
//                CLK_DIV=4, instance 1 uses CLK_DIV=2. A negedge monitor
//                collects rising-edge bit captures, nCS-low cycle counts,
//                SCLK half-period lengths and done timing per instance.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_spi_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start [2];
    logic       rw    [2];
    logic [6:0] addr  [2];
    logic [7:0] data  [2];
    logic       busy  [2];
    logic       done  [2];
    logic       ncs   [2];
    logic       sclk  [2];
    logic       copi  [2];
`ifdef SPI_CTRL_ABORT_EN
    logic       abort [2];
`endif

    always #5 clk = ~clk;

    spi_controller #(.CLK_DIV(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .rw(rw[0]),
        .addr(addr[0]), .data(data[0]),
`ifdef SPI_CTRL_ABORT_EN
        .abort(abort[0]),
`endif
        .busy(busy[0]), .done(done[0]), .nCS_out(ncs[0]),
        .SCLK_out(sclk[0]), .COPI_out(copi[0])
    );

    spi_controller #(.CLK_DIV(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .rw(rw[1]),
        .addr(addr[1]), .data(data[1]),
`ifdef SPI_CTRL_ABORT_EN
        .abort(abort[1]),
`endif
        .busy(busy[1]), .done(done[1]), .nCS_out(ncs[1]),
        .SCLK_out(sclk[1]), .COPI_out(copi[1])
    );

    // ------------------------------------------------------------------ monitor
    int          cyc = 0;
    int          rises     [2] = '{0, 0};
    int          rises_hi  [2] = '{0, 0};
    int          ncs_low   [2] = '{0, 0};
    int          done_cnt  [2] = '{0, 0};
    int          done_cyc  [2] = '{0, 0};
    int          fall_cyc  [2] = '{0, 0};
    int          hi_run    [2] = '{0, 0};
    int          last_gap  [2] = '{0, 0};
    int          run       [2] = '{0, 0};
    int          bad_run   [2] = '{0, 0};
    int          copi_bad  [2] = '{0, 0};
    logic [15:0] cap       [2] = '{16'h0, 16'h0};
    logic [15:0] frame_done[2] = '{16'h0, 16'h0};
    logic        p_sclk    [2] = '{1'b0, 1'b0};
    logic        p_copi    [2] = '{1'b0, 1'b0};
    logic        p_ncs     [2] = '{1'b1, 1'b1};

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (sclk[k] && !p_sclk[k]) begin
                rises[k] <= rises[k] + 1;
                cap[k]   <= {cap[k][14:0], copi[k]};
                if (ncs[k]) rises_hi[k] <= rises_hi[k] + 1;
            end
            if (sclk[k] && p_sclk[k] && (copi[k] != p_copi[k]))
                copi_bad[k] <= copi_bad[k] + 1;
            // SCLK half-period lengths, measured only while selected
            if (ncs[k]) begin
                run[k] <= 0;
            end else if (sclk[k] != p_sclk[k]) begin
                if (run[k] != ((k == 0) ? 4 : 2)) bad_run[k] <= bad_run[k] + 1;
                run[k] <= 1;
            end else begin
                run[k] <= run[k] + 1;
            end
            if (!ncs[k]) ncs_low[k] <= ncs_low[k] + 1;
            if (ncs[k]) begin
                hi_run[k] <= hi_run[k] + 1;
            end else if (p_ncs[k]) begin
                last_gap[k] <= hi_run[k];
                hi_run[k]   <= 0;
                fall_cyc[k] <= cyc;
            end
            if (done[k]) begin
                done_cnt[k]   <= done_cnt[k] + 1;
                done_cyc[k]   <= cyc;
                frame_done[k] <= cap[k];
            end
            p_sclk[k] <= sclk[k];
            p_copi[k] <= copi[k];
            p_ncs[k]  <= ncs[k];
        end
    end

    // ------------------------------------------------------------------ helpers
    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Request a frame; returns the cycle index of the accepting edge.
    task automatic start_frame(input int k, input logic f_rw, input logic [6:0] f_addr,
                               input logic [7:0] f_data, output int t0);
        @(negedge clk);
        start[k] = 1'b1; rw[k] = f_rw; addr[k] = f_addr; data[k] = f_data;
        @(posedge clk);
        #1;
        t0 = cyc;
        start[k] = 1'b0;
    endtask

    task automatic wait_done(input int k, input int prev, input int budget, input string tag);
        int n;
        n = 0;
        while (done_cnt[k] == prev && n < budget) begin
            @(negedge clk); #1; n++;
        end
        check(tag, (done_cnt[k] != prev), 1);
    endtask

    task automatic pulse_start_at(input int k, input int when);
        while (cyc < when) @(negedge clk);
        start[k] = 1'b1; addr[k] = 7'h7E; data[k] = 8'h00;
        @(negedge clk);
        start[k] = 1'b0;
    endtask

    // ------------------------------------------------------------------ stimulus
    int t0, r0, n0, d0, w, d1;

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            start[k] = 1'b0; rw[k] = 1'b0; addr[k] = 7'h0; data[k] = 8'h0;
`ifdef SPI_CTRL_ABORT_EN
            abort[k] = 1'b0;
`endif
        end
        repeat (3) @(negedge clk);
        #1;
        check("reset_ncs",  ncs[0],  1'b1);
        check("reset_sclk", sclk[0], 1'b0);
        check("reset_copi", copi[0], 1'b0);
        check("reset_busy", busy[0], 1'b0);
        check("reset_done", done[0], 1'b0);
        check("reset_ncs_b", ncs[1], 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // 1: basic frame, CLK_DIV=4, frame 0x80A5
        r0 = rises[0]; n0 = ncs_low[0]; d0 = done_cnt[0];
        start_frame(0, 1'b1, 7'h00, 8'hA5, t0);
        check("f1_busy_after_accept", busy[0], 1'b1);
        check("f1_ncs_after_accept",  ncs[0],  1'b0);
        check("f1_copi_first_bit",    copi[0], 1'b1);
        wait_done(0, d0, 400, "f1_done_timeout");
        check("f1_done_latency",  done_cyc[0] - t0, 140);
        check("f1_busy_in_done",  busy[0], 1'b0);
        check("f1_rises",         rises[0] - r0, 16);
        check("f1_ncs_low",       ncs_low[0] - n0, 132);
        check("f1_frame",         frame_done[0], 16'h80A5);
        @(negedge clk); #1;
        check("f1_done_one_cycle", done[0], 1'b0);
        check("f1_done_count",     done_cnt[0] - d0, 1);

        // 2: back-to-back, second start held through the done cycle
        d0 = done_cnt[0];
        start_frame(0, 1'b1, 7'h04, 8'hFF, t0);
        @(negedge clk);
        start[0] = 1'b1; rw[0] = 1'b1; addr[0] = 7'h02; data[0] = 8'h3C;
        wait_done(0, d0, 400, "b2b_done1_timeout");
        d1 = done_cyc[0];
        check("b2b_frame1", frame_done[0], 16'h84FF);
        check("b2b_latency1", d1 - t0, 140);
        @(posedge clk); #1;
        start[0] = 1'b0;
        wait_done(0, d0 + 1, 400, "b2b_done2_timeout");
        check("b2b_next_frame_start", fall_cyc[0] - d1, 1);
        check("b2b_gap", last_gap[0], 9);
        check("b2b_frame2", frame_done[0], 16'h823C);
        check("b2b_latency2", done_cyc[0] - d1, 141);

        // 3: starts during a frame are ignored
        repeat (5) @(negedge clk);
        r0 = rises[0]; d0 = done_cnt[0];
        start_frame(0, 1'b1, 7'h11, 8'h5A, t0);
        pulse_start_at(0, t0 + 10);
        pulse_start_at(0, t0 + 40);
        pulse_start_at(0, t0 + 100);
        wait_done(0, d0, 400, "ign_done_timeout");
        repeat (200) @(negedge clk);
        #1;
        check("ign_done_count", done_cnt[0] - d0, 1);
        check("ign_rises",      rises[0] - r0, 16);
        check("ign_frame",      frame_done[0], 16'h915A);
        check("ign_idle_after", busy[0], 1'b0);

        // 4: reset at the 7th rising edge abandons the frame
        r0 = rises[0]; d0 = done_cnt[0];
        start_frame(0, 1'b1, 7'h00, 8'hA5, t0);
        w = 0;
        while ((rises[0] - r0) < 7 && w < 400) begin
            @(negedge clk); #1; w++;
        end
        check("rst_reached_7th_rise", rises[0] - r0, 7);
        rst_n = 1'b0;
        #1;
        check("rst_ncs",  ncs[0],  1'b1);
        check("rst_sclk", sclk[0], 1'b0);
        check("rst_busy", busy[0], 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (150) @(negedge clk);
        #1;
        check("rst_no_done", done_cnt[0] - d0, 0);
        r0 = rises[0]; n0 = ncs_low[0];
        start_frame(0, 1'b1, 7'h33, 8'hC3, t0);
        wait_done(0, d0, 400, "rst_clean_done_timeout");
        check("rst_clean_rises",   rises[0] - r0, 16);
        check("rst_clean_ncs_low", ncs_low[0] - n0, 132);
        check("rst_clean_frame",   frame_done[0], 16'hB3C3);

        // 5: CLK_DIV=2 instance, rw=0 frame
        r0 = rises[1]; n0 = ncs_low[1]; d0 = done_cnt[1];
        start_frame(1, 1'b0, 7'h7F, 8'h01, t0);
        check("d2_copi_first_bit", copi[1], 1'b0);
        wait_done(1, d0, 200, "d2_done_timeout");
        check("d2_latency", done_cyc[1] - t0, 70);
        check("d2_rises",   rises[1] - r0, 16);
        check("d2_ncs_low", ncs_low[1] - n0, 66);
        check("d2_frame",   frame_done[1], 16'h7F01);

`ifdef SPI_CTRL_ABORT_EN
        // 6: abort after the 5th rising edge
        repeat (5) @(negedge clk);
        r0 = rises[0]; d0 = done_cnt[0];
        start_frame(0, 1'b1, 7'h00, 8'hA5, t0);
        w = 0;
        while ((rises[0] - r0) < 5 && w < 400) begin
            @(negedge clk); #1; w++;
        end
        check("abt_reached_5th_rise", rises[0] - r0, 5);
        abort[0] = 1'b1;
        @(posedge clk); #1;
        w = cyc;
        abort[0] = 1'b0;
        check("abt_ncs",  ncs[0],  1'b1);
        check("abt_sclk", sclk[0], 1'b0);
        check("abt_copi", copi[0], 1'b0);
        wait_done(0, d0, 100, "abt_done_timeout");
        check("abt_done_delay", done_cyc[0] - w, 8);
        check("abt_rises", rises[0] - r0, 5);
        // abort in IDLE with start: start wins
        d0 = done_cnt[0];
        @(negedge clk);
        abort[0] = 1'b1;
        start_frame(0, 1'b1, 7'h01, 8'h02, t0);
        abort[0] = 1'b0;
        wait_done(0, d0, 400, "abt_start_wins_timeout");
        check("abt_start_wins_latency", done_cyc[0] - t0, 140);
`endif

        // whole-run properties
        check("no_rise_while_deselected_4", rises_hi[0], 0);
        check("no_rise_while_deselected_2", rises_hi[1], 0);
        check("copi_stable_high_4", copi_bad[0], 0);
        check("copi_stable_high_2", copi_bad[1], 0);
        check("half_period_4", bad_run[0], 0);
        check("half_period_2", bad_run[1], 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
